// File: rtl/key_mode_ctrl.sv
// Key front end for the marquee display: synchronizes and debounces two active-low keys and steps a 2-bit mode.
// Optional build macro KEY_MODE_AUTO_EN adds a free-running auto-advance timer.
module key_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int AUTO_PERIOD     = 48000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] key_raw,
    output logic [1:0] mode_sw,
    output logic       mode_chg,
    output logic [1:0] key_db
);

    localparam int             CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]  DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ZERO = CW'(0);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic [1:0]         sync1_r;
    logic [1:0]         sync2_r;
    logic [1:0][CW-1:0] db_cnt_r;
    logic [1:0][CW-1:0] db_cnt_nxt_s;
    logic [1:0]         key_db_r;
    logic [1:0]         key_db_nxt_s;
    logic [1:0]         key_db_d_r;
    logic [1:0]         press_s;
    logic [1:0]         mode_r;
    logic [1:0]         mode_nxt_s;
    logic               mode_chg_r;
    logic               mode_chg_nxt_s;

    assign press_s  = key_db_d_r & ~key_db_r;
    assign mode_sw  = mode_r;
    assign mode_chg = mode_chg_r;
    assign key_db   = key_db_r;

`ifdef KEY_MODE_AUTO_EN
    localparam int             AW        = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [AW-1:0]  AUTO_LAST = AW'(AUTO_PERIOD - 1);
    localparam logic [AW-1:0]  AUTO_ZERO = AW'(0);
    localparam logic [AW-1:0]  AUTO_ONE  = AW'(1);

    logic [AW-1:0] auto_cnt_r;
    logic [AW-1:0] auto_cnt_nxt_s;
    logic          auto_hit_s;

    assign auto_hit_s = (auto_cnt_r == AUTO_LAST);

    // Auto timer next value; any press event restarts the period
    always_comb begin
        auto_cnt_nxt_s = auto_cnt_r;
        if (press_s != 2'b00) begin
            auto_cnt_nxt_s = AUTO_ZERO;
        end else if (auto_hit_s) begin
            auto_cnt_nxt_s = AUTO_ZERO;
        end else begin
            auto_cnt_nxt_s = auto_cnt_r + AUTO_ONE;
        end
    end

    // Auto timer register
    always_ff @(posedge clk) begin
        if (rst) begin
            auto_cnt_r <= AUTO_ZERO;
        end else begin
            auto_cnt_r <= auto_cnt_nxt_s;
        end
    end
`endif

    // Debounce: any sample matching the accepted level restarts the count
    always_comb begin
        db_cnt_nxt_s = db_cnt_r;
        key_db_nxt_s = key_db_r;
        for (int i = 0; i < 2; i++) begin
            if (sync2_r[i] == key_db_r[i]) begin
                db_cnt_nxt_s[i] = CNT_ZERO;
            end else if (db_cnt_r[i] == DB_LAST) begin
                key_db_nxt_s[i] = sync2_r[i];
                db_cnt_nxt_s[i] = CNT_ZERO;
            end else begin
                db_cnt_nxt_s[i] = db_cnt_r[i] + CNT_ONE;
            end
        end
    end

    // Mode step: presses win over the auto advance; both keys together cancel out
    always_comb begin
        mode_nxt_s     = mode_r;
        mode_chg_nxt_s = 1'b0;
        case (press_s)
            2'b01: begin
                mode_nxt_s     = mode_r + 2'b01;
                mode_chg_nxt_s = 1'b1;
            end
            2'b10: begin
                mode_nxt_s     = mode_r - 2'b01;
                mode_chg_nxt_s = 1'b1;
            end
            2'b11: begin
                mode_nxt_s     = mode_r;
                mode_chg_nxt_s = 1'b0;
            end
            default: begin
`ifdef KEY_MODE_AUTO_EN
                if (auto_hit_s) begin
                    mode_nxt_s     = mode_r + 2'b01;
                    mode_chg_nxt_s = 1'b1;
                end else begin
                    mode_nxt_s     = mode_r;
                    mode_chg_nxt_s = 1'b0;
                end
`else
                mode_nxt_s     = mode_r;
                mode_chg_nxt_s = 1'b0;
`endif
            end
        endcase
    end

    // Synchronizers, debounce state and mode registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r    <= 2'b11;
            sync2_r    <= 2'b11;
            db_cnt_r   <= {2{CNT_ZERO}};
            key_db_r   <= 2'b11;
            key_db_d_r <= 2'b11;
            mode_r     <= 2'b00;
            mode_chg_r <= 1'b0;
        end else begin
            sync1_r    <= key_raw;
            sync2_r    <= sync1_r;
            db_cnt_r   <= db_cnt_nxt_s;
            key_db_r   <= key_db_nxt_s;
            key_db_d_r <= key_db_r;
            mode_r     <= mode_nxt_s;
            mode_chg_r <= mode_chg_nxt_s;
        end
    end

endmodule
